// File: rtl/alu_ram_sequencer.sv
// alu_ram_sequencer: one-command-at-a-time controller for a 16x8 register RAM
// (two combinational read ports, one write port) and an external ALU.
// Commands are LOAD, ALU, READ or illegal. Each command ends in one response.
module alu_ram_sequencer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int OP_W   = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_kind,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [ADDR_W-1:0] cmd_src0,
  input  logic [ADDR_W-1:0] cmd_src1,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] ram_addr0_read,
  output logic [ADDR_W-1:0] ram_addr1_read,
  input  logic [DATA_W-1:0] ram_data0_read,
  input  logic [DATA_W-1:0] ram_data1_read,
  output logic [ADDR_W-1:0] ram_addr_write,
  output logic [DATA_W-1:0] ram_data_write,
  output logic              ram_write_enable,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result
);

  localparam logic [1:0] K_LOAD = 2'b00;
  localparam logic [1:0] K_ALU  = 2'b01;
  localparam logic [1:0] K_READ = 2'b10;
  localparam logic [1:0] K_ILL  = 2'b11;

  typedef enum logic [2:0] {IDLE, FETCH, EXEC, WRITE, RESP} state_t;

  state_t              state_q, state_d;
  logic                ready_q;
  logic [1:0]          kind_q;
  logic [OP_W-1:0]     op_q;
  logic [ADDR_W-1:0]   raddr0_q, raddr1_q;
  logic [DATA_W-1:0]   opa_q, opb_q;
  logic [ADDR_W-1:0]   waddr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                rerr_q;
  logic                accept;

  // ready_q is only ever set while the FSM sits in IDLE, so it alone gates acceptance
  assign accept = cmd_valid && ready_q;

  assign cmd_ready      = ready_q;
  assign rsp_data       = rdata_q;
  assign rsp_err        = rerr_q;
  assign ram_addr0_read = raddr0_q;
  assign ram_addr1_read = raddr1_q;
  assign ram_addr_write = waddr_q;
  assign ram_data_write = wdata_q;
  assign alu_a          = opa_q;
  assign alu_b          = opb_q;
  assign alu_op         = op_q;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state decode plus write strobe and response valid
  always_comb begin
    state_d          = state_q;
    ram_write_enable = 1'b0;
    rsp_valid        = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        case (cmd_kind)
          K_LOAD:  state_d = WRITE;
          K_ALU:   state_d = FETCH;
          K_READ:  state_d = FETCH;
          default: state_d = RESP;
        endcase
      end
      FETCH: state_d = (kind_q == K_ALU) ? EXEC : RESP;
      EXEC:  state_d = WRITE;
      WRITE: begin
        ram_write_enable = 1'b1;
        state_d          = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // cmd_ready is registered so it stays low in reset and rises one edge later
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) ready_q <= 1'b0;
    else          ready_q <= (state_d == IDLE);
  end

  // Datapath: capture command on acceptance, operands in FETCH, result in EXEC
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      kind_q   <= K_LOAD;
      op_q     <= '0;
      raddr0_q <= '0;
      raddr1_q <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rerr_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          kind_q <= cmd_kind;
          rerr_q <= (cmd_kind == K_ILL);
          if (cmd_kind == K_ALU) op_q <= cmd_op;
          if (cmd_kind == K_ALU || cmd_kind == K_READ) begin
            raddr0_q <= cmd_src0;
            raddr1_q <= cmd_src1;
          end
          if (cmd_kind == K_LOAD || cmd_kind == K_ALU) waddr_q <= cmd_dst;
          if (cmd_kind == K_LOAD) wdata_q <= cmd_imm;
          if (cmd_kind == K_ILL)  rdata_q <= '0;
        end
        // Operands are latched before any write, so dst may alias a source
        FETCH: begin
          if (kind_q == K_ALU) begin
            opa_q <= ram_data0_read;
            opb_q <= ram_data1_read;
          end else begin
            rdata_q <= ram_data0_read;
          end
        end
        EXEC:  wdata_q <= alu_result;
        WRITE: rdata_q <= wdata_q;
        default: ;
      endcase
    end
  end

endmodule
